// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/buffer sizes, receiver FSM states and
// the mid-bit sample point helper used by both directions.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Last count of the half-bit wait used to re-check the start bit at its centre.
  function automatic logic [15:0] half_bit_last(input logic [15:0] baud_div);
    return (baud_div >> 1) - 16'd1;
  endfunction

  // Last count of a full bit period.
  function automatic logic [15:0] full_bit_last(input logic [15:0] baud_div);
    return baud_div - 16'd1;
  endfunction

endpackage

// File: rtl/wbit_fifo.sv
// Synchronous word FIFO; registered read data one cycle after a read request.
// Writes while full and reads while empty are ignored; write and read together keep occupancy.
module wbit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             re_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign do_wr   = we_i && !full_o;
  assign do_rd   = re_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout_o <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_o <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling FSM, frames buffered in wbit_fifo.
// Stop-bit errors and frames arriving while the buffer is full are dropped with a one-cycle pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  rx_state_t             state, state_nxt;
  logic [15:0]           baud_cnt, baud_nxt;
  logic [3:0]            bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  sync1, rx_s;
  logic                  fifo_we;
  logic                  frame_err;
  logic                  overrun;
  logic [15:0]           half_last;
  logic [15:0]           bit_last;

  assign half_last = half_bit_last(baud_div_i);
  assign bit_last  = full_bit_last(baud_div_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_bit_i;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    fifo_we   = 1'b0;
    frame_err = 1'b0;
    overrun   = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        // Enable only gates new start bits; a frame in flight always completes.
        if (rx_en_i && !rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (baud_cnt == half_last) begin
          baud_nxt  = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_cnt == bit_last) begin
          baud_nxt = '0;
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == 4'(i)) begin
              shift_nxt[i] = rx_s;
            end
          end
          if (bit_cnt == LAST_BIT) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_cnt == bit_last) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
          // full_o is this cycle's occupancy, so a same-cycle read cannot make room.
          if (!rx_s) begin
            frame_err = 1'b1;
          end else if (full_o) begin
            overrun = 1'b1;
          end else begin
            fifo_we = 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign frame_err_o = frame_err && !rst_i;
  assign overrun_o   = overrun && !rst_i;

  wbit_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (fifo_we),
    .din_i   (shift),
    .re_i    (rx_re_i),
    .dout_o  (dout_o),
    .empty_o (empty_o),
    .full_o  (full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a queue model.
module tb_uart_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b1;
  logic          rx_bit = 1'b1;
  logic          rx_re = 1'b0;
  logic [15:0]   baud_div = 16'd16;
  logic [DW-1:0] dout;
  logic          empty, full, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_div_i  (baud_div),
    .rx_en_i     (rx_en),
    .rx_bit_i    (rx_bit),
    .rx_re_i     (rx_re),
    .dout_o      (dout),
    .empty_o     (empty),
    .full_o      (full),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  int n_checks = 0;
  int n_err    = 0;
  int fe_seen  = 0;
  int ov_seen  = 0;
  int fe_exp   = 0;
  int ov_exp   = 0;
  logic [7:0] model_q [$];
  logic [7:0] last_rd = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (overrun)   ov_seen++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one complete frame as seen from the buffer.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) fe_exp++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else ov_exp++;
  endtask

  // Drives one line frame; optional read during data bit rd_bit, optional enable drop at drop_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int rd_bit,
                            input int drop_bit, input bit counted);
    int d;
    bit do_rd;
    logic [7:0] exp_rd;
    d = int'(baud_div);
    do_rd = (rd_bit >= 0) && (model_q.size() > 0);
    exp_rd = 8'h00;
    if (do_rd) exp_rd = model_q.pop_front();
    rx_bit = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      if (i == drop_bit) rx_en = 1'b0;
      if (do_rd && i == rd_bit) begin
        rx_re = 1'b1;
        tick(1);
        rx_re = 1'b0;
        check_val("midframe_read", dout, exp_rd);
        last_rd = exp_rd;
        tick(d - 1);
      end else begin
        tick(d);
      end
    end
    rx_bit = stop_ok;
    tick(d);
    rx_bit = 1'b1;
    if (counted) model_frame(b, stop_ok);
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_ok, input int rd_bit);
    send_frame(b, stop_ok, rd_bit, -1, 1'b1);
    tick(2 * int'(baud_div));
    check_val("frame_err_count", fe_seen, fe_exp);
    check_val("overrun_count", ov_seen, ov_exp);
    check_val("empty_after_frame", empty, model_q.size() == 0);
    check_val("full_after_frame", full, model_q.size() == DEPTH);
  endtask

  task automatic pop_check(input string tag);
    if (model_q.size() == 0) begin
      rx_re = 1'b1;
      tick(1);
      rx_re = 1'b0;
      check_val("read_empty_ignored", empty, 1'b1);
      check_val("read_empty_dout", dout, last_rd);
    end else begin
      last_rd = model_q.pop_front();
      rx_re = 1'b1;
      tick(1);
      rx_re = 1'b0;
      check_val(tag, dout, last_rd);
    end
  endtask

  initial begin
    logic [7:0] part;
    tick(5);
    check_val("reset_empty", empty, 1'b1);
    check_val("reset_full", full, 1'b0);
    check_val("reset_frame_err", frame_err, 1'b0);
    check_val("reset_overrun", overrun, 1'b0);
    check_val("reset_dout", dout, 8'h00);
    rst = 1'b0;
    tick(4);

    // Basic frame
    frame(8'hA5, 1'b1, -1);
    pop_check("read_a5");
    check_val("empty_after_a5", empty, 1'b1);

    // Short low glitch must be rejected and leave the receiver ready
    rx_bit = 1'b0;
    tick(5);
    rx_bit = 1'b1;
    tick(40);
    check_val("glitch_empty", empty, 1'b1);
    check_val("glitch_no_err", fe_seen, 0);
    frame(8'h5A, 1'b1, -1);
    pop_check("read_after_glitch");

    // Bad stop bit
    frame(8'h3C, 1'b0, -1);
    check_val("stop_err_pulses", fe_seen, 1);
    check_val("stop_err_empty", empty, 1'b1);

    // Enable dropped mid-frame completes the frame, then blocks the next one
    send_frame(8'h96, 1'b1, -1, 3, 1'b1);
    tick(32);
    send_frame(8'h69, 1'b1, -1, -1, 1'b0);
    tick(32);
    rx_en = 1'b1;
    tick(4);
    pop_check("read_en_drop");
    check_val("disabled_frame_ignored", empty, 1'b1);

    // Fill, overrun, drain in order
    for (int i = 0; i <= 16; i++) begin
      frame(8'(i), 1'b1, -1);
      if (i == 15) check_val("full_after_16", full, 1'b1);
    end
    check_val("overrun_once", ov_seen, 1);
    for (int i = 0; i < 16; i++) pop_check("drain_order");
    check_val("drained_empty", empty, 1'b1);
    check_val("drained_not_full", full, 1'b0);

    // Reset during data bit 3 discards the partial byte and the buffer
    frame(8'h11, 1'b1, -1);
    part = 8'hF0;
    rx_bit = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx_bit = part[i];
      tick(16);
    end
    rx_bit = part[3];
    tick(8);
    rst = 1'b1;
    tick(3);
    rx_bit = 1'b1;
    tick(20);
    rst = 1'b0;
    model_q.delete();
    last_rd = 8'h00;
    tick(32);
    check_val("rst_mid_empty", empty, 1'b1);
    check_val("rst_mid_dout", dout, 8'h00);
    frame(8'h81, 1'b1, -1);
    pop_check("read_81");
    check_val("only_81", empty, 1'b1);

    // Transmitter-style back-to-back frames at divisor 104
    baud_div = 16'd104;
    send_frame(8'h55, 1'b1, -1, -1, 1'b1);
    send_frame(8'hFF, 1'b1, -1, -1, 1'b1);
    send_frame(8'h00, 1'b1, -1, -1, 1'b1);
    tick(208);
    check_val("loop_no_err", fe_seen, fe_exp);
    check_val("loop_no_ovr", ov_seen, ov_exp);
    for (int i = 0; i < 3; i++) pop_check("loopback_read");

    // Random frames, divisors, stop errors and reads
    for (int n = 0; n < 40; n++) begin
      int rb;
      baud_div = 16'($urandom_range(4, 20));
      rb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
      frame(8'($urandom), ($urandom_range(0, 4) != 0), rb);
      if ($urandom_range(0, 2) == 0) pop_check("random_read");
    end
    while (model_q.size() > 0) pop_check("final_drain");
    check_val("final_empty", empty, 1'b1);
    pop_check("final_read_empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
